// File: rtl/ddr3_read_arbiter.sv
// ddr3_read_arbiter
//
// Two-requester round-robin arbiter in front of an Avalon-MM DDR3 read port.
// Each accepted request issues one fixed-length read burst; the returning
// beats are tagged with the originating requester and its 2-bit tag, taken
// from an in-order tag FIFO that also serves as the outstanding-burst credit
// counter.
//
// Optional feature: define DDR3_RD_ARB_ERR_EN to add the sticky protocol_err
// output, which flags return beats that arrive with no burst outstanding.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   req0_addr_* / req1_addr_* valid/ready request streams, data = {tag[1:0], addr[26:0]}
//   avm_address/read/burstcount/waitrequest   Avalon-MM read command
//   avm_readdata/readdatavalid                Avalon-MM read return
//   rsp_valid/src/tag/last/data               registered, tagged return beat
//   protocol_err             (DDR3_RD_ARB_ERR_EN only) sticky orphan-beat flag
module ddr3_read_arbiter #(
  parameter int unsigned BURST_LEN       = 15,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [28:0]  req0_addr_data,
  input  logic         req0_addr_valid,
  output logic         req0_addr_ready,
  input  logic [28:0]  req1_addr_data,
  input  logic         req1_addr_valid,
  output logic         req1_addr_ready,
  output logic [26:0]  avm_address,
  output logic         avm_read,
  output logic [7:0]   avm_burstcount,
  input  logic         avm_waitrequest,
  input  logic [255:0] avm_readdata,
  input  logic         avm_readdatavalid,
  output logic         rsp_valid,
  output logic         rsp_src,
  output logic [1:0]   rsp_tag,
  output logic         rsp_last,
  output logic [255:0] rsp_data
`ifdef DDR3_RD_ARB_ERR_EN
  ,
  output logic         protocol_err
`endif
);

  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_e;

  state_e         state_q, state_d;
  logic [26:0]    avm_address_q, avm_address_d;
  logic           avm_read_q, avm_read_d;
  logic [7:0]     avm_burstcount_q, avm_burstcount_d;
  logic           last_grant_q, last_grant_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [7:0]     beat_cnt_q, beat_cnt_d;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0]     fifo_q [MAX_OUTSTANDING];

  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_src_q, rsp_src_d;
  logic [1:0]     rsp_tag_q, rsp_tag_d;
  logic           rsp_last_q, rsp_last_d;
  logic [255:0]   rsp_data_q, rsp_data_d;

  logic           credit, can_grant, grant_src, accept;
  logic [26:0]    accept_addr;
  logic [1:0]     accept_tag;
  logic           fifo_empty, beat_ok, beat_last, push, pop;

  // Arbitration: tie goes to the requester that did not win last time.
  always_comb begin
    credit    = outstanding_q < CntW'(MAX_OUTSTANDING);
    // Gated by reset_n so both readies read 0 while reset is held.
    can_grant = reset_n && (state_q == ST_IDLE) && credit;
    if (req0_addr_valid && req1_addr_valid) begin
      grant_src = ~last_grant_q;
    end else begin
      grant_src = ~req0_addr_valid;
    end
    req0_addr_ready = can_grant && req0_addr_valid && !grant_src;
    req1_addr_ready = can_grant && req1_addr_valid && grant_src;
    accept          = req0_addr_ready || req1_addr_ready;
    accept_addr     = grant_src ? req1_addr_data[26:0] : req0_addr_data[26:0];
    accept_tag      = grant_src ? req1_addr_data[28:27] : req0_addr_data[28:27];
  end

  // Command FSM next state and command register next values.
  always_comb begin
    state_d          = state_q;
    avm_read_d       = avm_read_q;
    avm_address_d    = avm_address_q;
    avm_burstcount_d = avm_burstcount_q;
    last_grant_d     = last_grant_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d          = ST_ISSUE;
          avm_read_d       = 1'b1;
          avm_address_d    = accept_addr;
          avm_burstcount_d = 8'(BURST_LEN);
          last_grant_d     = grant_src;
        end
      end
      ST_ISSUE: begin
        if (!avm_waitrequest) begin
          state_d    = ST_IDLE;
          avm_read_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Return path: the FIFO occupancy equals the outstanding count, so an
  // empty FIFO means the beat belongs to no burst and is dropped.
  always_comb begin
    fifo_empty    = (outstanding_q == '0);
    beat_ok       = avm_readdatavalid && !fifo_empty;
    beat_last     = (beat_cnt_q == 8'(BURST_LEN - 1));
    push          = accept;
    pop           = beat_ok && beat_last;
    outstanding_d = outstanding_q + CntW'(push) - CntW'(pop);
    beat_cnt_d    = beat_cnt_q;
    if (beat_ok) begin
      beat_cnt_d = beat_last ? 8'd0 : beat_cnt_q + 8'd1;
    end
    rsp_valid_d = 1'b0;
    rsp_src_d   = 1'b0;
    rsp_tag_d   = 2'b00;
    rsp_last_d  = 1'b0;
    rsp_data_d  = '0;
    if (beat_ok) begin
      rsp_valid_d            = 1'b1;
      {rsp_src_d, rsp_tag_d} = fifo_q[rd_ptr_q];
      rsp_last_d             = beat_last;
      rsp_data_d             = avm_readdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      avm_read_q       <= 1'b0;
      avm_address_q    <= '0;
      avm_burstcount_q <= '0;
      last_grant_q     <= 1'b1;
      outstanding_q    <= '0;
      beat_cnt_q       <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        fifo_q[i] <= '0;
      end
      rsp_valid_q <= 1'b0;
      rsp_src_q   <= 1'b0;
      rsp_tag_q   <= 2'b00;
      rsp_last_q  <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      avm_read_q       <= avm_read_d;
      avm_address_q    <= avm_address_d;
      avm_burstcount_q <= avm_burstcount_d;
      last_grant_q     <= last_grant_d;
      outstanding_q    <= outstanding_d;
      beat_cnt_q       <= beat_cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= {grant_src, accept_tag};
        wr_ptr_q         <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_src_q   <= rsp_src_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_last_q  <= rsp_last_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

`ifdef DDR3_RD_ARB_ERR_EN
  logic protocol_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      protocol_err_q <= 1'b0;
    end else if (avm_readdatavalid && fifo_empty) begin
      protocol_err_q <= 1'b1;
    end
  end

  assign protocol_err = protocol_err_q;
`endif

  assign avm_address    = avm_address_q;
  assign avm_read       = avm_read_q;
  assign avm_burstcount = avm_burstcount_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_src        = rsp_src_q;
  assign rsp_tag        = rsp_tag_q;
  assign rsp_last       = rsp_last_q;
  assign rsp_data       = rsp_data_q;

endmodule

// File: tb/tb_ddr3_read_arbiter.sv
// Directed self-checking bench for ddr3_read_arbiter (default parameters:
// 15-beat bursts, 4 outstanding). Inputs change on the falling edge; all
// outputs are sampled 1 ns later.
module tb_ddr3_read_arbiter;

  logic         clk;
  logic         reset_n;
  logic [28:0]  req0_addr_data, req1_addr_data;
  logic         req0_addr_valid, req1_addr_valid;
  logic         req0_addr_ready, req1_addr_ready;
  logic [26:0]  avm_address;
  logic         avm_read;
  logic [7:0]   avm_burstcount;
  logic         avm_waitrequest;
  logic [255:0] avm_readdata;
  logic         avm_readdatavalid;
  logic         rsp_valid, rsp_src, rsp_last;
  logic [1:0]   rsp_tag;
  logic [255:0] rsp_data;
`ifdef DDR3_RD_ARB_ERR_EN
  logic         protocol_err;
`endif

  int vecs = 0;
  int errs = 0;

  ddr3_read_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .req0_addr_data    (req0_addr_data),
    .req0_addr_valid   (req0_addr_valid),
    .req0_addr_ready   (req0_addr_ready),
    .req1_addr_data    (req1_addr_data),
    .req1_addr_valid   (req1_addr_valid),
    .req1_addr_ready   (req1_addr_ready),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_burstcount    (avm_burstcount),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .rsp_valid         (rsp_valid),
    .rsp_src           (rsp_src),
    .rsp_tag           (rsp_tag),
    .rsp_last          (rsp_last),
    .rsp_data          (rsp_data)
`ifdef DDR3_RD_ARB_ERR_EN
    ,
    .protocol_err      (protocol_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want $finish");
    $fatal(1);
  end

  function automatic logic [255:0] pat(input int k);
    return {8{32'hC0DE0000 + 32'(k)}};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset_n           = 1'b0;
    req0_addr_valid   = 1'b0;
    req1_addr_valid   = 1'b0;
    req0_addr_data    = '0;
    req1_addr_data    = '0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Presents one request and waits (bounded) until it is accepted; returns at
  // the falling edge of the following (issue) cycle with valid dropped.
  task automatic issue(input bit src, input logic [1:0] tag, input logic [26:0] addr);
    int n;
    @(negedge clk);
    if (src) begin
      req1_addr_data = {tag, addr}; req1_addr_valid = 1'b1;
    end else begin
      req0_addr_data = {tag, addr}; req0_addr_valid = 1'b1;
    end
    #1;
    n = 0;
    while (!(src ? req1_addr_ready : req0_addr_ready) && n < 20) begin
      @(negedge clk); #1; n++;
    end
    vecs++;
    if (n >= 20) begin
      errs++;
      $display("FAIL issue_ready src%0d: got no ready in %0d cycles want ready", src, n);
    end
    @(negedge clk);
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n         = 1'b0;
    req0_addr_valid = 1'b1;
    req1_addr_valid = 1'b1;
    req0_addr_data  = {2'b01, 27'h1234567};
    req1_addr_data  = {2'b10, 27'h7654321};
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata    = pat(7);
    #1;
    vecs++;
    if ({req1_addr_ready, req0_addr_ready} !== 2'b00) begin
      errs++; $display("FAIL reset_ready: got %b want 00", {req1_addr_ready, req0_addr_ready});
    end
    @(negedge clk); #1;
    vecs++;
    if ({avm_read, avm_address, avm_burstcount} !== 36'd0) begin
      errs++; $display("FAIL reset_cmd: got %b/%h/%0d want 0/0/0", avm_read, avm_address,
                       avm_burstcount);
    end
    vecs++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== 5'd0 || rsp_data !== '0) begin
      errs++; $display("FAIL reset_rsp: got %b%b%b%b want 00000", rsp_valid, rsp_src, rsp_tag,
                       rsp_last);
    end
`ifdef DDR3_RD_ARB_ERR_EN
    vecs++;
    if (protocol_err !== 1'b0) begin
      errs++; $display("FAIL reset_err: got %b want 0", protocol_err);
    end
`endif
    do_reset();
  endtask

  // Single request with waitrequest stretching the command, then one burst.
  task automatic test_single();
    logic [4:0] exp_t;
    do_reset();
    @(negedge clk);
    req0_addr_data  = {2'b01, 27'h0005A00};
    req0_addr_valid = 1'b1;
    avm_waitrequest = 1'b1;
    #1;
    vecs++;
    if ({req1_addr_ready, req0_addr_ready} !== 2'b01) begin
      errs++; $display("FAIL single_grant: got %b want 01", {req1_addr_ready, req0_addr_ready});
    end
    for (int h = 0; h < 4; h++) begin
      @(negedge clk);
      req0_addr_valid = 1'b0;
      if (h == 3) avm_waitrequest = 1'b0;
      #1;
      vecs++;
      if (avm_read !== 1'b1 || avm_address !== 27'h0005A00 || avm_burstcount !== 8'd15 ||
          req0_addr_ready !== 1'b0) begin
        errs++; $display("FAIL single_hold cyc%0d: got %b/%h/%0d want 1/0005a00/15", h, avm_read,
                         avm_address, avm_burstcount);
      end
    end
    @(negedge clk); #1;
    vecs++;
    if (avm_read !== 1'b0) begin
      errs++; $display("FAIL single_read_drop: got %b want 0", avm_read);
    end
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 15);
      avm_readdata      = pat(k);
      #1;
      if (k > 0) begin
        exp_t = {1'b1, 1'b0, 2'b01, ((k - 1) == 14)};
        vecs++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== exp_t || rsp_data !== pat(k - 1)) begin
          errs++; $display("FAIL single_beat%0d: got %b data %h want %b data %h", k - 1,
                           {rsp_valid, rsp_src, rsp_tag, rsp_last}, rsp_data[31:0], exp_t,
                           pat(k - 1) & 256'hFFFFFFFF);
        end
      end
    end
    @(negedge clk); #1;
    vecs++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== 5'd0 || rsp_data !== '0) begin
      errs++; $display("FAIL single_idle_rsp: got %b want 00000",
                       {rsp_valid, rsp_src, rsp_tag, rsp_last});
    end
  endtask

  // Both requesters always valid: grants alternate 0,1,0,1, credit runs out,
  // and the first completed burst frees a credit for the next cycle.
  task automatic test_round_robin();
    logic [1:0] exp_r;
    logic [4:0] exp_t;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) begin
        req0_addr_data = {2'b00, 27'h0000100}; req0_addr_valid = 1'b1;
        req1_addr_data = {2'b10, 27'h0000200}; req1_addr_valid = 1'b1;
      end
      #1;
      exp_r = (c < 8 && c % 4 == 0) ? 2'b01 : (c < 8 && c % 4 == 2) ? 2'b10 : 2'b00;
      vecs++;
      if ({req1_addr_ready, req0_addr_ready} !== exp_r) begin
        errs++; $display("FAIL rr_ready cyc%0d: got %b want %b", c,
                         {req1_addr_ready, req0_addr_ready}, exp_r);
      end
      if (c < 8 && c % 2 == 1) begin
        vecs++;
        if (avm_read !== 1'b1 || avm_address !== ((c % 4 == 1) ? 27'h100 : 27'h200)) begin
          errs++; $display("FAIL rr_addr cyc%0d: got %b/%h want 1/%h", c, avm_read, avm_address,
                           (c % 4 == 1) ? 27'h100 : 27'h200);
        end
      end
    end
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 15);
      avm_readdata      = pat(k);
      #1;
      if (k == 14) begin
        vecs++;
        if ({req1_addr_ready, req0_addr_ready} !== 2'b00) begin
          errs++; $display("FAIL rr_full: got %b want 00", {req1_addr_ready, req0_addr_ready});
        end
      end
      if (k == 15) begin
        exp_t = 5'b1_0_00_1;
        vecs++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== exp_t) begin
          errs++; $display("FAIL rr_last: got %b want %b", {rsp_valid, rsp_src, rsp_tag, rsp_last},
                           exp_t);
        end
        vecs++;
        if ({req1_addr_ready, req0_addr_ready} !== 2'b01) begin
          errs++; $display("FAIL rr_credit_free: got %b want 01",
                           {req1_addr_ready, req0_addr_ready});
        end
      end
    end
    req0_addr_valid = 1'b0;
    req1_addr_valid = 1'b0;
  endtask

  // Final beat of the oldest burst lands on the same edge as a new accept
  // while 3 are outstanding: count must stay 3, tags return in order.
  task automatic test_coincide();
    bit         exp_src [4];
    logic [1:0] exp_tag [4];
    logic [4:0] exp_t;
    int         b;
    do_reset();
    issue(1'b0, 2'd0, 27'h10);
    issue(1'b1, 2'd1, 27'h20);
    issue(1'b0, 2'd2, 27'h30);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      avm_readdatavalid = 1'b1;
      avm_readdata      = pat(k);
      if (k == 14) begin
        req1_addr_data  = {2'd3, 27'h40};
        req1_addr_valid = 1'b1;
      end
      #1;
      if (k == 14) begin
        vecs++;
        if (req1_addr_ready !== 1'b1) begin
          errs++; $display("FAIL co_accept: got %b want 1", req1_addr_ready);
        end
      end
    end
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    req1_addr_valid   = 1'b0;
    #1;
    vecs++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== 5'b1_0_00_1 || avm_address !== 27'h40) begin
      errs++; $display("FAIL co_lastA: got %b addr %h want 10001 addr 40",
                       {rsp_valid, rsp_src, rsp_tag, rsp_last}, avm_address);
    end
    @(negedge clk);
    req0_addr_data  = {2'd0, 27'h50};
    req0_addr_valid = 1'b1;
    #1;
    vecs++;
    if (req0_addr_ready !== 1'b1) begin
      errs++; $display("FAIL co_count3: got ready %b want 1", req0_addr_ready);
    end
    @(negedge clk);
    req0_addr_valid = 1'b0;
    @(negedge clk);
    req1_addr_valid = 1'b1;
    #1;
    vecs++;
    if ({req1_addr_ready, req0_addr_ready} !== 2'b00) begin
      errs++; $display("FAIL co_count4: got %b want 00", {req1_addr_ready, req0_addr_ready});
    end
    req1_addr_valid = 1'b0;
    exp_src[0] = 1'b1; exp_tag[0] = 2'd1;
    exp_src[1] = 1'b0; exp_tag[1] = 2'd2;
    exp_src[2] = 1'b1; exp_tag[2] = 2'd3;
    exp_src[3] = 1'b0; exp_tag[3] = 2'd0;
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 60);
      avm_readdata      = pat(k + 100);
      #1;
      if (k > 0) begin
        b     = (k - 1) / 15;
        exp_t = {1'b1, exp_src[b], exp_tag[b], ((k - 1) % 15 == 14)};
        vecs++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== exp_t || rsp_data !== pat(k + 99)) begin
          errs++; $display("FAIL co_beat%0d: got %b want %b", k - 1,
                           {rsp_valid, rsp_src, rsp_tag, rsp_last}, exp_t);
        end
      end
    end
  endtask

  // Return beat with nothing outstanding is ignored and leaves the beat
  // counter alone.
  task automatic test_drop();
    logic [4:0] exp_t;
    do_reset();
    @(negedge clk);
    avm_readdatavalid = 1'b1;
    avm_readdata      = pat(99);
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    #1;
    vecs++;
    if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_last !== 1'b0) begin
      errs++; $display("FAIL drop_rsp: got valid %b last %b want 0 0", rsp_valid, rsp_last);
    end
    issue(1'b0, 2'd1, 27'h77);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 15);
      avm_readdata      = pat(k + 200);
      #1;
      if (k > 0) begin
        exp_t = {1'b1, 1'b0, 2'd1, ((k - 1) == 14)};
        vecs++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== exp_t) begin
          errs++; $display("FAIL drop_after_beat%0d: got %b want %b", k - 1,
                           {rsp_valid, rsp_src, rsp_tag, rsp_last}, exp_t);
        end
      end
    end
`ifdef DDR3_RD_ARB_ERR_EN
    vecs++;
    if (protocol_err !== 1'b1) begin
      errs++; $display("FAIL drop_err_sticky: got %b want 1", protocol_err);
    end
    do_reset();
    #1;
    vecs++;
    if (protocol_err !== 1'b0) begin
      errs++; $display("FAIL drop_err_clear: got %b want 0", protocol_err);
    end
`endif
  endtask

  // Reset after 8 beats of a burst, orphan beats afterwards, then a clean burst.
  task automatic test_reset_mid();
    logic [4:0] exp_t;
    do_reset();
    issue(1'b0, 2'd3, 27'h7FF0000);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      avm_readdatavalid = 1'b1;
      avm_readdata      = pat(k + 300);
    end
    @(negedge clk);
    reset_n         = 1'b0;
    req0_addr_valid = 1'b1;
    avm_readdata    = pat(308);
    #1;
    vecs++;
    if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== 5'd0 || rsp_data !== '0 ||
        {avm_read, avm_address, avm_burstcount} !== 36'd0 || req0_addr_ready !== 1'b0) begin
      errs++; $display("FAIL mid_reset_outputs: got rsp %b cmd %b/%h/%0d rdy %b want all 0",
                       {rsp_valid, rsp_src, rsp_tag, rsp_last}, avm_read, avm_address,
                       avm_burstcount, req0_addr_ready);
    end
    @(negedge clk);
    reset_n         = 1'b1;
    req0_addr_valid = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 6);
      #1;
      vecs++;
      if (rsp_valid !== 1'b0) begin
        errs++; $display("FAIL mid_orphan%0d: got rsp_valid %b want 0", k, rsp_valid);
      end
    end
    avm_readdatavalid = 1'b0;
    issue(1'b1, 2'd2, 27'h123);
    for (int k = 0; k <= 15; k++) begin
      @(negedge clk);
      avm_readdatavalid = (k < 15);
      avm_readdata      = pat(k + 400);
      #1;
      if (k > 0) begin
        exp_t = {1'b1, 1'b1, 2'd2, ((k - 1) == 14)};
        vecs++;
        if ({rsp_valid, rsp_src, rsp_tag, rsp_last} !== exp_t || rsp_data !== pat(k + 399)) begin
          errs++; $display("FAIL mid_post_beat%0d: got %b want %b", k - 1,
                           {rsp_valid, rsp_src, rsp_tag, rsp_last}, exp_t);
        end
      end
    end
  endtask

  initial begin
    reset_n           = 1'b0;
    req0_addr_valid   = 1'b0;
    req1_addr_valid   = 1'b0;
    req0_addr_data    = '0;
    req1_addr_data    = '0;
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_coincide();
    test_drop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/ddr3_read_arbiter.md
DDR3_READ_ARBITER -- requirements
Module: ddr3_read_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 15, beats per read burst (one 240-px third-row, 2 B/px, 32 B/beat).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, maximum bursts issued but not fully returned; power of 2, 2..16.
REQ-003 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0_addr_data, input, 29; req0_addr_valid, input, 1; req0_addr_ready, output, 1: requester 0 stream, {tag[1:0], addr[26:0]}.
REQ-006 SHALL have ports req1_addr_data, input, 29; req1_addr_valid, input, 1; req1_addr_ready, output, 1: requester 1, same format.
REQ-007 SHALL have ports avm_address, output, 27; avm_read, output, 1; avm_burstcount, output, 8; avm_waitrequest, input, 1: Avalon-MM read command.
REQ-008 SHALL have ports avm_readdata, input, 256; avm_readdatavalid, input, 1: Avalon-MM read return.
REQ-009 SHALL have ports rsp_valid, output, 1; rsp_src, output, 1; rsp_tag, output, 2; rsp_last, output, 1; rsp_data, output, 256: tagged return beat.

Function
REQ-010 SHALL implement FSM states ST_IDLE and ST_ISSUE.
REQ-011 In ST_IDLE with credit available (outstanding < MAX_OUTSTANDING), SHALL assert reqN_addr_ready combinationally only for the granted valid requester; the other ready SHALL be 0.
REQ-012 Grant: single valid requester wins; both valid -> requester opposite to last_grant wins (round-robin); last_grant updates on each accept.
REQ-013 On accept (valid & ready), SHALL register addr into avm_address, drive avm_read=1, avm_burstcount=BURST_LEN, push {src, tag} into tag FIFO, enter ST_ISSUE.
REQ-014 In ST_ISSUE, SHALL hold avm_read, avm_address and avm_burstcount stable while avm_waitrequest=1; on avm_waitrequest=0 deassert avm_read next cycle and return to ST_IDLE.
REQ-015 Both reqN_addr_ready SHALL be 0 in ST_ISSUE and when outstanding = MAX_OUTSTANDING; at most one accept per two cycles.
REQ-016 Beat counter SHALL count avm_readdatavalid beats 0..BURST_LEN-1 and wrap to 0 after the last beat.
REQ-017 SHALL register each return beat: rsp_valid, rsp_data=avm_readdata, rsp_src/rsp_tag=tag FIFO head, one cycle after avm_readdatavalid (latency 1).
REQ-018 rsp_last SHALL be 1 with the BURST_LEN-th beat of a burst; the tag FIFO pops and outstanding decrements on that beat.
REQ-019 Push and pop in the same cycle SHALL leave outstanding unchanged; FIFO read/write pointers wrap modulo MAX_OUTSTANDING.
REQ-020 A freed credit SHALL allow an accept in the cycle after the pop.
REQ-021 avm_readdatavalid with the tag FIFO empty SHALL be dropped: rsp_valid stays 0, counter unchanged.
REQ-022 rsp_* SHALL be 0 when rsp_valid is 0.

Reset
REQ-023 On reset_n=0 SHALL asynchronously force ST_IDLE, avm_read=0, avm_address=0, avm_burstcount=0, both ready=0, rsp_*=0, outstanding=0, beat counter=0, FIFO pointers=0, last_grant=1 (requester 0 wins first tie).
REQ-024 Reset mid-burst SHALL discard all in-flight tags; beats returning after release with the FIFO empty SHALL follow REQ-021.
REQ-025 Reset release SHALL take effect on the first rising clk edge after reset_n rises.

Configuration
REQ-026 Macro DDR3_RD_ARB_ERR_EN defined: SHALL add output protocol_err (1 bit, reset 0), set sticky on any REQ-021 event and cleared only by reset.
REQ-027 Macro DDR3_RD_ARB_ERR_EN undefined: protocol_err port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-028 Both requesters valid continuously, waitrequest=0, immediate returns -> grants alternate 0,1,0,1; first grant requester 0.
REQ-029 req0 addr {2'b01, 27'h0005A00}, waitrequest high 3 cycles -> avm_address=27'h0005A00, burstcount=15 held 4 cycles, then one burst of 15 rsp beats with rsp_src=0, rsp_tag=1, rsp_last only on beat 15.
REQ-030 Withhold readdatavalid, issue 4 requests -> ready=0 after 4th accept; first rsp_last -> accept possible next cycle.
REQ-031 Final beat of burst A coincides with accept of burst B at outstanding=3 -> outstanding stays 3; B's tag returns after the tags ahead of it.
REQ-032 Pulse readdatavalid with no request issued -> no rsp_valid; with DDR3_RD_ARB_ERR_EN, protocol_err=1 until reset.
REQ-033 Assert reset_n=0 mid-burst after beat 7 -> all outputs 0 immediately; post-reset request completes normally with 15 beats.
